// File: rtl/usb_nrzi_tx.sv
// USB transmit line encoder: arbitrates byte sources, sends SYNC, bit-stuffed NRZI data,
// then an SE0/J end-of-packet before returning the line to J idle.
module usb_nrzi_tx #(
  parameter int N_SRC        = 2,
  parameter int CLK_PER_BIT  = 1,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2,
  parameter int LOW_SPEED    = 0
) (
  input  logic               useClk,
  input  logic               rstN,
  input  logic [8*N_SRC-1:0] txData,
  input  logic [N_SRC-1:0]   txValid,
  input  logic [N_SRC-1:0]   txLast,
  output logic [N_SRC-1:0]   txReady,
  output logic [N_SRC-1:0]   grant,
  output logic               dp,
  output logic               dm,
  output logic               oe,
  output logic               underrun
);

  localparam int DW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int SW = $clog2(STUFF_LEN + 1);
  localparam logic J_DP = (LOW_SPEED == 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    sync_cnt;
  logic [7:0]    shreg;
  logic [3:0]    bits_left;
  logic          last_byte;
  logic [SW-1:0] stuff_cnt;
  logic [2:0]    eop_cnt;

  logic             tick, in_data, byte_done, need_stuff, load;
  logic             sel_valid, sel_last;
  logic [7:0]       sel_data;
  logic [N_SRC-1:0] first_req;
  logic             place_bit, bit_val;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    first_req = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        sel_valid = sel_valid | txValid[i];
        sel_last  = sel_last | txLast[i];
        sel_data  = sel_data | txData[8*i +: 8];
      end
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (txValid[i]) begin
        first_req    = '0;
        first_req[i] = 1'b1;
      end
    end
  end

  // The end of SYNC behaves like the end of an empty, non-last byte so the first load shares the data path.
  assign tick       = (state != IDLE) && (div == DW'(CLK_PER_BIT - 1));
  assign in_data    = (state == DATA) || ((state == SYNC) && (sync_cnt == 3'd7));
  assign byte_done  = (state == SYNC) || (bits_left == 4'd0);
  assign need_stuff = (stuff_cnt == SW'(STUFF_LEN));
  assign load       = tick && in_data && !need_stuff && byte_done && !last_byte;
  assign txReady    = (load && sel_valid) ? grant : '0;
  assign underrun   = load && !sel_valid;

  always_comb begin
    place_bit = 1'b0;
    bit_val   = 1'b0;
    if (state == IDLE) begin
      place_bit = |txValid;
    end else if (tick && (state == SYNC) && (sync_cnt != 3'd7)) begin
      place_bit = 1'b1;
      bit_val   = (sync_cnt == 3'd6);
    end else if (tick && in_data) begin
      if (need_stuff) begin
        place_bit = 1'b1;
      end else if (!byte_done) begin
        place_bit = 1'b1;
        bit_val   = shreg[0];
      end else if (load && sel_valid) begin
        place_bit = 1'b1;
        bit_val   = sel_data[0];
      end
    end
  end

  always_ff @(posedge useClk) begin
    if (!rstN) begin
      state     <= IDLE;
      div       <= '0;
      sync_cnt  <= '0;
      shreg     <= '0;
      bits_left <= '0;
      last_byte <= 1'b0;
      stuff_cnt <= '0;
      eop_cnt   <= '0;
      grant     <= '0;
      oe        <= 1'b0;
      dp        <= J_DP;
      dm        <= !J_DP;
    end else begin
      if (place_bit) begin
        if (!bit_val) begin
          dp <= dm;
          dm <= dp;
        end
        stuff_cnt <= bit_val ? stuff_cnt + 1'b1 : '0;
      end
      div <= ((state == IDLE) || tick) ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          if (|txValid) begin
            state     <= SYNC;
            grant     <= first_req;
            oe        <= 1'b1;
            sync_cnt  <= '0;
            bits_left <= '0;
            last_byte <= 1'b0;
          end
        end
        SYNC, DATA: begin
          if (tick) begin
            if (!in_data) begin
              sync_cnt <= sync_cnt + 1'b1;
            end else if (need_stuff) begin
              state <= DATA;
            end else if (!byte_done) begin
              shreg     <= shreg >> 1;
              bits_left <= bits_left - 1'b1;
            end else if (load && sel_valid) begin
              shreg     <= sel_data >> 1;
              bits_left <= 4'd7;
              last_byte <= sel_last;
              state     <= DATA;
            end else begin
              state   <= EOP_SE0;
              dp      <= 1'b0;
              dm      <= 1'b0;
              eop_cnt <= '0;
            end
          end
        end
        EOP_SE0: begin
          if (tick) begin
            if (eop_cnt == 3'(EOP_SE0_BITS - 1)) begin
              state <= EOP_J;
              dp    <= J_DP;
              dm    <= !J_DP;
            end else begin
              eop_cnt <= eop_cnt + 1'b1;
            end
          end
        end
        EOP_J: begin
          if (tick) begin
            state <= IDLE;
            oe    <= 1'b0;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Bench for usb_nrzi_tx: expected line symbols are built from bit lists (SYNC, stuffed data, EOP)
// and compared cycle by cycle; a second instance covers the bit-rate divider and mid-packet reset.
module tb_usb_nrzi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, dp, dm, oe, underrun;
  logic [15:0] txData;
  logic [1:0]  txValid, txLast, txReady, grant;

  logic        rstN4, dp4, dm4, oe4, underrun4;
  logic [15:0] txData4;
  logic [1:0]  txValid4, txLast4, txReady4, grant4;

  usb_nrzi_tx #(.N_SRC(2), .CLK_PER_BIT(1)) dut (
    .useClk(clk), .rstN(rstN), .txData(txData), .txValid(txValid), .txLast(txLast),
    .txReady(txReady), .grant(grant), .dp(dp), .dm(dm), .oe(oe), .underrun(underrun)
  );

  usb_nrzi_tx #(.N_SRC(2), .CLK_PER_BIT(4)) dut4 (
    .useClk(clk), .rstN(rstN4), .txData(txData4), .txValid(txValid4), .txLast(txLast4),
    .txReady(txReady4), .grant(grant4), .dp(dp4), .dm(dm4), .oe(oe4), .underrun(underrun4)
  );

  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_bytes [2][8];
  int         src_avail [2];
  bit         src_has_last [2];
  int         src_idx [2];

  logic [1:0] exp_line [$];
  logic       exp_oe [$];
  logic [1:0] exp_grant [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [1:0] line, input logic o, input logic [1:0] g, input int rep);
    for (int r = 0; r < rep; r++) begin
      exp_line.push_back(line);
      exp_oe.push_back(o);
      exp_grant.push_back(g);
    end
  endtask

  // Raw bits are SYNC then each byte LSB first; a 0 is inserted after every six consecutive 1s.
  task automatic add_packet(input int s, input int rep);
    int raw [$];
    int bits [$];
    int ones;
    logic [1:0] lvl;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7 ? 1 : 0);
    for (int b = 0; b < src_avail[s]; b++)
      for (int k = 0; k < 8; k++) raw.push_back(int'(src_bytes[s][b][k]));
    ones = 0;
    foreach (raw[i]) begin
      bits.push_back(raw[i]);
      ones = (raw[i] == 1) ? ones + 1 : 0;
      if (ones == 6) begin
        bits.push_back(0);
        ones = 0;
      end
    end
    lvl = LINE_J;
    foreach (bits[i]) begin
      if (bits[i] == 0) lvl = {lvl[0], lvl[1]};
      push_sym(lvl, 1'b1, 2'(1 << s), rep);
    end
    push_sym(LINE_SE0, 1'b1, 2'(1 << s), 2 * rep);
    push_sym(LINE_J, 1'b1, 2'(1 << s), rep);
  endtask

  task automatic clear_expected();
    exp_line.delete();
    exp_oe.delete();
    exp_grant.delete();
  endtask

  task automatic drive_sources();
    for (int s = 0; s < 2; s++) begin
      txValid[s] = (src_idx[s] < src_avail[s]);
      txData[8*s +: 8] = txValid[s] ? src_bytes[s][src_idx[s]] : 8'h00;
      txLast[s] = txValid[s] && src_has_last[s] && (src_idx[s] == src_avail[s] - 1);
    end
  endtask

  // Starts at a negedge with the sources already driven; the next posedge is the start edge.
  task automatic run_stream(input bit use4, output int ready_pulses, output int underruns);
    logic [1:0] rcap;
    rcap = '0;
    ready_pulses = 0;
    underruns = 0;
    for (int k = 0; k < exp_line.size(); k++) begin
      @(posedge clk);
      #1;
      if (!use4) begin
        for (int s = 0; s < 2; s++) if (rcap[s]) src_idx[s]++;
        drive_sources();
      end
      @(negedge clk);
      check($sformatf("line[%0d]", k), use4 ? {dp4, dm4} : {dp, dm}, exp_line[k]);
      check($sformatf("oe[%0d]", k), use4 ? oe4 : oe, exp_oe[k]);
      check($sformatf("grant[%0d]", k), use4 ? grant4 : grant, exp_grant[k]);
      rcap = use4 ? txReady4 : txReady;
      ready_pulses += $countones(rcap);
      underruns += int'(use4 ? underrun4 : underrun);
    end
  endtask

  task automatic setup_src(input int s, input int n, input bit has_last);
    src_avail[s] = n;
    src_has_last[s] = has_last;
    src_idx[s] = 0;
  endtask

  initial begin
    int rp, ur, s, n, total;
    rstN = 1'b0; rstN4 = 1'b0;
    txData = '0; txValid = '0; txLast = '0;
    txData4 = '0; txValid4 = '0; txLast4 = '0;
    for (int i = 0; i < 2; i++) begin
      src_avail[i] = 0; src_has_last[i] = 1'b0; src_idx[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_line", {dp, dm}, LINE_J);
    check("reset_oe", oe, 1'b0);
    check("reset_grant", grant, 2'b00);
    check("reset_ready", txReady, 2'b00);
    check("reset_underrun", underrun, 1'b0);
    rstN = 1'b1; rstN4 = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_line", {dp, dm}, LINE_J);
    check("idle_oe", oe, 1'b0);
    check("idle_grant", grant, 2'b00);

    $display("[TB] single byte 0x00");
    src_bytes[0][0] = 8'h00; setup_src(0, 1, 1'b1); setup_src(1, 0, 1'b0);
    clear_expected(); add_packet(0, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
    check("single_len", exp_line.size(), 20);
    drive_sources(); run_stream(1'b0, rp, ur);
    check("single_ready", rp, 1);
    check("single_underrun", ur, 0);

    $display("[TB] stuffing 0xFF");
    src_bytes[0][0] = 8'hFF; setup_src(0, 1, 1'b1);
    clear_expected(); add_packet(0, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
    check("stuff_len", exp_line.size(), 17 + 3 + 1);
    drive_sources(); run_stream(1'b0, rp, ur);
    check("stuff_ready", rp, 1);

    $display("[TB] stuffing across byte boundary");
    src_bytes[1][0] = 8'hF0; src_bytes[1][1] = 8'hFF; src_bytes[1][2] = 8'h7E;
    setup_src(0, 0, 1'b0); setup_src(1, 3, 1'b1);
    clear_expected(); add_packet(1, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
    drive_sources(); run_stream(1'b0, rp, ur);
    check("boundary_ready", rp, 3);

    $display("[TB] arbitration");
    src_bytes[0][0] = 8'h3C; src_bytes[0][1] = 8'hA1; src_bytes[1][0] = 8'h5A;
    setup_src(0, 2, 1'b1); setup_src(1, 1, 1'b1);
    clear_expected(); add_packet(0, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
    add_packet(1, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
    drive_sources(); run_stream(1'b0, rp, ur);
    check("arb_ready", rp, 3);

    $display("[TB] underrun");
    src_bytes[0][0] = 8'h96; setup_src(0, 1, 1'b0); setup_src(1, 0, 1'b0);
    clear_expected(); add_packet(0, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
    drive_sources(); run_stream(1'b0, rp, ur);
    check("underrun_pulses", ur, 1);
    check("underrun_ready", rp, 1);

    $display("[TB] random packets");
    for (int it = 0; it < 4; it++) begin
      s = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      for (int b = 0; b < n; b++) src_bytes[s][b] = 8'($urandom);
      setup_src(0, 0, 1'b0); setup_src(1, 0, 1'b0); setup_src(s, n, 1'b1);
      clear_expected(); add_packet(s, 1); push_sym(LINE_J, 1'b0, 2'b00, 1);
      drive_sources(); run_stream(1'b0, rp, ur);
      check($sformatf("rand%0d_ready", it), rp, n);
    end
    setup_src(0, 0, 1'b0); setup_src(1, 0, 1'b0); drive_sources();

    $display("[TB] divider and mid-packet reset");
    src_bytes[0][0] = 8'hA5; setup_src(0, 1, 1'b1);
    clear_expected(); add_packet(0, 4);
    while (exp_line.size() > 48) begin
      void'(exp_line.pop_back()); void'(exp_oe.pop_back()); void'(exp_grant.pop_back());
    end
    setup_src(0, 0, 1'b0);
    txData4 = 16'h00A5; txValid4 = 2'b01; txLast4 = 2'b01;
    run_stream(1'b1, rp, ur);
    check("div_ready", rp, 1);
    @(posedge clk); #1;
    rstN4 = 1'b0; txValid4 = 2'b00;
    @(posedge clk); #1;
    rstN4 = 1'b1;
    @(negedge clk);
    check("div_reset_line", {dp4, dm4}, LINE_J);
    check("div_reset_oe", oe4, 1'b0);
    check("div_reset_grant", grant4, 2'b00);
    repeat (4) @(negedge clk);
    check("div_after_line", {dp4, dm4}, LINE_J);
    check("div_after_oe", oe4, 1'b0);

    total = checks;
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
